// File: rtl/accel_seq_ctrl.sv
// rtl/accel_seq_ctrl.sv - register-file sequencer: writes five operands, waits LAT cycles, reads two result words.
// Optional ACCEL_CTRL_PERF_CNT_EN adds saturating response/stall counters.
module accel_seq_ctrl #(
    parameter int N            = 32,
    parameter int RF_ADDR_BITS = 3,
    parameter int LAT          = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [N-1:0]            i_op_a,
    input  logic [N-1:0]            i_op_b,
    input  logic [N-1:0]            i_op_k,
    input  logic [N-1:0]            i_op_x,
    input  logic [N-1:0]            i_op_c,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [2*N-1:0]          o_rsp_data,
    output logic [RF_ADDR_BITS-1:0] o_rf_addr,
    output logic [N-1:0]            o_rf_data,
    output logic                    o_rf_we,
    input  logic [N-1:0]            i_rf_data,
`ifdef ACCEL_CTRL_PERF_CNT_EN
    output logic [15:0]             o_perf_ops,
    output logic [15:0]             o_perf_stall,
`endif
    output logic                    o_busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WAIT, S_RD_LO, S_RD_HI, S_CAP, S_RESP
    } state_e;

    localparam logic [7:0] WAIT_INIT = 8'(LAT - 1);

    state_e         state_q, state_d;
    logic [2:0]     wr_cnt_q, wr_cnt_d;
    logic [7:0]     wait_cnt_q, wait_cnt_d;
    logic [N-1:0]   a_q, b_q, k_q, x_q, c_q;
    logic [N-1:0]   res_lo_q, res_hi_q;
    logic           cmd_hs;

    assign cmd_hs = (state_q == S_IDLE) && i_cmd_valid;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            wr_cnt_q   <= '0;
            wait_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            k_q        <= '0;
            x_q        <= '0;
            c_q        <= '0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            if (cmd_hs) begin
                a_q <= i_op_a;
                b_q <= i_op_b;
                k_q <= i_op_k;
                x_q <= i_op_x;
                c_q <= i_op_c;
            end
            // Register file returns data one cycle after the address, so each word lands a state later.
            if (state_q == S_RD_HI) res_lo_q <= i_rf_data;
            if (state_q == S_CAP)   res_hi_q <= i_rf_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    state_d  = S_WR;
                    wr_cnt_d = '0;
                end
            end
            S_WR: begin
                if (wr_cnt_q == 3'd4) begin
                    state_d    = S_WAIT;
                    wr_cnt_d   = '0;
                    wait_cnt_d = WAIT_INIT;
                end else begin
                    wr_cnt_d = wr_cnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 8'd0) state_d = S_RD_LO;
                else                    wait_cnt_d = wait_cnt_q - 8'd1;
            end
            S_RD_LO: state_d = S_RD_HI;
            S_RD_HI: state_d = S_CAP;
            S_CAP:   state_d = S_RESP;
            S_RESP:  if (i_rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_rf_addr = '0;
        o_rf_data = '0;
        o_rf_we   = 1'b0;
        unique case (state_q)
            S_WR: begin
                o_rf_we   = 1'b1;
                o_rf_addr = RF_ADDR_BITS'(wr_cnt_q);
                case (wr_cnt_q)
                    3'd0:    o_rf_data = a_q;
                    3'd1:    o_rf_data = b_q;
                    3'd2:    o_rf_data = k_q;
                    3'd3:    o_rf_data = x_q;
                    default: o_rf_data = c_q;
                endcase
            end
            S_WAIT, S_RD_LO: o_rf_addr = RF_ADDR_BITS'(5);
            S_RD_HI:         o_rf_addr = RF_ADDR_BITS'(6);
            default: ;
        endcase
    end

    assign o_cmd_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_data  = {res_hi_q, res_lo_q};

`ifdef ACCEL_CTRL_PERF_CNT_EN
    logic [15:0] perf_ops_q, perf_stall_q;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else if (state_q == S_RESP) begin
            if (i_rsp_ready) begin
                if (perf_ops_q != 16'hFFFF) perf_ops_q <= perf_ops_q + 16'd1;
            end else begin
                if (perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign o_perf_ops   = perf_ops_q;
    assign o_perf_stall = perf_stall_q;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_accel_seq_ctrl.sv
// tb/tb_accel_seq_ctrl.sv - self-checking bench for accel_seq_ctrl (default LAT and LAT=1 instances).
module tb_accel_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] op_a, op_b, op_k, op_x, op_c;

    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rf_we, busy;
    logic [63:0] rsp_data;
    logic [2:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;

    logic        cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, rf_we1, busy1;
    logic [63:0] rsp_data1;
    logic [2:0]  rf_addr1;
    logic [31:0] rf_wdata1, rf_rdata1;

`ifdef ACCEL_CTRL_PERF_CNT_EN
    logic [15:0] perf_ops, perf_stall, perf_ops1, perf_stall1;
`endif

    accel_seq_ctrl #(.N(32), .RF_ADDR_BITS(3), .LAT(8)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_op_a(op_a), .i_op_b(op_b), .i_op_k(op_k), .i_op_x(op_x), .i_op_c(op_c),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
        .o_rf_addr(rf_addr), .o_rf_data(rf_wdata), .o_rf_we(rf_we), .i_rf_data(rf_rdata),
`ifdef ACCEL_CTRL_PERF_CNT_EN
        .o_perf_ops(perf_ops), .o_perf_stall(perf_stall),
`endif
        .o_busy(busy)
    );

    accel_seq_ctrl #(.N(32), .RF_ADDR_BITS(3), .LAT(1)) dut1 (
        .i_clk(clk), .i_reset(rst_n),
        .i_cmd_valid(cmd_valid1), .o_cmd_ready(cmd_ready1),
        .i_op_a(op_a), .i_op_b(op_b), .i_op_k(op_k), .i_op_x(op_x), .i_op_c(op_c),
        .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1), .o_rsp_data(rsp_data1),
        .o_rf_addr(rf_addr1), .o_rf_data(rf_wdata1), .o_rf_we(rf_we1), .i_rf_data(rf_rdata1),
`ifdef ACCEL_CTRL_PERF_CNT_EN
        .o_perf_ops(perf_ops1), .o_perf_stall(perf_stall1),
`endif
        .o_busy(busy1)
    );

    function automatic logic [63:0] model(input logic [31:0] a, b, k, x, c);
        return 64'(a) * 64'(b) * (64'(x) + 64'(k)) + 64'(c);
    endfunction

    // Register-file stand-ins: result words at addr 5/6 computed from the operands at 0..4.
    logic [31:0] mem0 [8] = '{default: 32'd0};
    logic [31:0] mem1 [8] = '{default: 32'd0};
    logic [63:0] res0, res1;
    always_comb res0 = model(mem0[0], mem0[1], mem0[2], mem0[3], mem0[4]);
    always_comb res1 = model(mem1[0], mem1[1], mem1[2], mem1[3], mem1[4]);

    always @(posedge clk) begin
        if (rf_we) mem0[rf_addr] <= rf_wdata;
        rf_rdata <= (rf_addr == 3'd5) ? res0[31:0] : (rf_addr == 3'd6) ? res0[63:32] : mem0[rf_addr];
        if (rf_we1) mem1[rf_addr1] <= rf_wdata1;
        rf_rdata1 <= (rf_addr1 == 3'd5) ? res1[31:0] : (rf_addr1 == 3'd6) ? res1[63:32] : mem1[rf_addr1];
    end

    int n_checks = 0;
    int n_errors = 0;
    int n_rsp    = 0;
    logic [63:0] exp_q [$];
    time         hs_t  [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard for the default-LAT instance: push on command handshake, pop on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back(model(op_a, op_b, op_k, op_x, op_c));
                hs_t.push_back($time + 5);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 64'd1, 64'd0);
                else                   check("rsp_data", rsp_data, exp_q.pop_front());
                n_rsp++;
            end
        end
    end

    task automatic set_ops(input logic [31:0] a, b, k, x, c);
        op_a = a; op_b = b; op_k = k; op_x = x; op_c = c;
    endtask

    initial begin
        time t_e, t_r;
        int  k, seen, base;
        logic [63:0] held;
        logic [31:0] exp_w [5];

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_valid1 = 1'b0; rsp_ready1 = 1'b1;
        set_ops(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_data", rsp_data, 64'd0);
        check("rst_rf_we", {63'd0, rf_we}, 64'd0);
        check("rst_rf_addr", {61'd0, rf_addr}, 64'd0);
        check("rst_rf_data", {32'd0, rf_wdata}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;

        // Basic command: operands written in order, response after 8+LAT edges.
        @(posedge clk); #1;
        set_ops(2, 3, 4, 5, 7);
        exp_w = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd7};
        cmd_valid = 1'b1;
        @(posedge clk); t_e = $time; #1;
        cmd_valid = 1'b0;
        set_ops(32'hDEAD, 32'hBEEF, 32'h1111, 32'h2222, 32'h3333);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("wr_we", {63'd0, rf_we}, 64'd1);
            check("wr_addr", {61'd0, rf_addr}, 64'(i));
            check("wr_data", {32'd0, rf_wdata}, {32'd0, exp_w[i]});
        end
        @(negedge clk);
        check("wait_we", {63'd0, rf_we}, 64'd0);
        check("wait_addr", {61'd0, rf_addr}, 64'd5);
        check("wait_busy", {63'd0, busy}, 64'd1);
        k = 6;
        while (!rsp_valid && k < 60) begin @(negedge clk); k++; end
        t_r = $time;
        check("rsp_latency", 64'((t_r - t_e - 5) / 10), 64'd16);

        // Hold the response for 20 cycles; an intervening command pulse must be ignored.
        held = rsp_data;
        check("rsp_value", held, 64'd61);
        for (int i = 0; i < 20; i++) begin
            check("stall_data", rsp_data, held);
            check("stall_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            @(posedge clk); #1;
            if (i == 5) cmd_valid = 1'b1;
            if (i == 6) cmd_valid = 1'b0;
            if (i == 19) rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        check("post_rsp_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rsp_count_1", 64'(n_rsp), 64'd1);
`ifdef ACCEL_CTRL_PERF_CNT_EN
        check("perf_ops", {48'd0, perf_ops}, 64'd1);
        check("perf_stall", {48'd0, perf_stall}, 64'd20);
`endif

        // Back-to-back commands with valid and ready held high.
        base = hs_t.size();
        @(posedge clk); #1;
        set_ops(1, 2, 3, 4, 5);
        cmd_valid = 1'b1;
        k = 0;
        while (hs_t.size() < base + 1 && k < 60) begin @(posedge clk); #1; k++; end
        set_ops(6, 7, 8, 9, 10);
        k = 0;
        while (hs_t.size() < base + 2 && k < 60) begin @(posedge clk); #1; k++; end
        cmd_valid = 1'b0;
        check("b2b_handshakes", 64'(hs_t.size()), 64'(base + 2));
        if (hs_t.size() >= base + 2)
            check("b2b_spacing", 64'((hs_t[base + 1] - hs_t[base]) / 10), 64'd18);
        k = 0;
        while (n_rsp < 3 && k < 60) begin @(negedge clk); k++; end
        check("rsp_count_3", 64'(n_rsp), 64'd3);

        // Asynchronous reset during WAIT aborts without a response.
        @(posedge clk); #1;
        set_ops(9, 9, 9, 9, 9);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_rf_we", {63'd0, rf_we}, 64'd0);
        check("arst_rf_addr", {61'd0, rf_addr}, 64'd0);
        check("arst_rsp_data", rsp_data, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin @(negedge clk); if (rsp_valid) seen++; end
        check("no_rsp_after_abort", 64'(seen), 64'd0);
        @(posedge clk); #1;
        set_ops(3, 3, 1, 1, 2);
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (n_rsp < 4 && k < 60) begin @(negedge clk); k++; end
        check("rsp_count_4", 64'(n_rsp), 64'd4);

        // LAT=1 instance: addr 5 right after the writes, response 9 edges after handshake.
        @(posedge clk); #1;
        set_ops(2, 3, 4, 5, 7);
        cmd_valid1 = 1'b1;
        @(posedge clk); t_e = $time; #1;
        cmd_valid1 = 1'b0;
        repeat (6) @(negedge clk);
        check("lat1_wait_we", {63'd0, rf_we1}, 64'd0);
        check("lat1_wait_addr", {61'd0, rf_addr1}, 64'd5);
        k = 6;
        while (!rsp_valid1 && k < 40) begin @(negedge clk); k++; end
        t_r = $time;
        check("lat1_latency", 64'((t_r - t_e - 5) / 10), 64'd9);
        check("lat1_rsp_data", rsp_data1, model(2, 3, 4, 5, 7));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
